traffic_lamp_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 36 +++
 rtl/lamp_code_decode.sv | 45 ++++
 rtl/traffic_lamp_monitor.sv | 191 +++++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared constants for the traffic lamp monitor slice: controller signal
// codes, one-hot lamp drive patterns, monitor mode encodings and the bit
// positions inside fault_cause.
// ---------------------------------------------------------------------------
package traffic_pkg;

  // Controller signal codes
  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b011;

  // Vehicle lamp drives, one-hot {green, yellow, red}
  localparam logic [2:0] VL_RED = 3'b001;
  localparam logic [2:0] VL_YEL = 3'b010;
  localparam logic [2:0] VL_GRN = 3'b100;
  localparam logic [2:0] VL_OFF = 3'b000;

  // Pedestrian lamp drives, {walk, dont_walk}
  localparam logic [1:0] PL_DONT = 2'b01;
  localparam logic [1:0] PL_WALK = 2'b10;

  // Monitor modes as seen on the mode output
  typedef enum logic [1:0] {
    STARTUP = 2'b00,
    NORMAL  = 2'b01,
    FAULT   = 2'b10
  } mode_t;

  // Bit positions inside fault_cause
  localparam int CAUSE_VEH = 0;
  localparam int CAUSE_PED = 1;
  localparam int CAUSE_ILL = 2;

endpackage

// File: rtl/lamp_code_decode.sv
// ---------------------------------------------------------------------------
// lamp_code_decode
// Combinational decode of one 3-bit controller code into a lamp drive.
// PED selects pedestrian decoding (2-bit {walk, dont_walk}) instead of
// vehicle decoding (3-bit one-hot {green, yellow, red}).
// Ports:
//   code    - 3-bit controller code
//   lamp    - decoded lamp drive (LW bits)
//   illegal - high when code is not a legal value for this lamp type;
//             an illegal code always decodes to red / dont_walk
// ---------------------------------------------------------------------------
module lamp_code_decode
  import traffic_pkg::*;
#(
  parameter bit PED = 1'b0,
  localparam int LW = PED ? 2 : 3
) (
  input  logic [2:0]    code,
  output logic [LW-1:0] lamp,
  output logic          illegal
);

  // Pedestrian signals have no yellow, so 010 is illegal for them. Anything
  // unrecognised falls back to the safe red / dont_walk drive.
  always_comb begin
    illegal = 1'b0;
    if (PED) begin
      lamp = LW'(PL_DONT);
      case (code)
        RED:     lamp = LW'(PL_DONT);
        GRN:     lamp = LW'(PL_WALK);
        default: illegal = 1'b1;
      endcase
    end else begin
      lamp = LW'(VL_RED);
      case (code)
        RED:     lamp = LW'(VL_RED);
        YEL:     lamp = LW'(VL_YEL);
        GRN:     lamp = LW'(VL_GRN);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// ---------------------------------------------------------------------------
// traffic_lamp_monitor
// Sits between the traffic light controller and the lamp pins. Decodes the
// four signal codes into registered lamp drives, holds all-red after reset
// or fault clear, and latches a flashing-red fault on persistent conflicts
// or illegal codes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   ns_code/ew_code - vehicle codes (001 red, 010 yellow, 011 green)
//   p_ns/p_ew_code  - pedestrian codes (001 dont_walk, 011 walk)
//   fault_clr       - request to leave fault mode
//   ns/ew_lamp      - one-hot {green, yellow, red}
//   p_ns/p_ew_lamp  - {walk, dont_walk}
//   fault           - latched fault flag
//   fault_cause     - {illegal, pedestrian conflict, vehicle conflict}
//   mode            - 00 STARTUP, 01 NORMAL, 10 FAULT
//   fault_count     - (only with TRAFFIC_LAMP_FAULT_CNT_EN) saturating count
//                     of NORMAL->FAULT entries, untouched by fault_clr
// ---------------------------------------------------------------------------
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int STARTUP_CYCLES   = 8,
  parameter int CONFLICT_PERSIST = 2,
  parameter int FLASH_HALF       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ns_code,
  input  logic [2:0] ew_code,
  input  logic [2:0] p_ns_code,
  input  logic [2:0] p_ew_code,
  input  logic       fault_clr,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [1:0] p_ns_lamp,
  output logic [1:0] p_ew_lamp,
  output logic       fault,
  output logic [2:0] fault_cause,
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
  output logic [7:0] fault_count,
`endif
  output logic [1:0] mode
);

  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam int PW = $clog2(CONFLICT_PERSIST + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_CYCLES - 1);
  localparam logic [PW-1:0] PC_LAST = PW'(CONFLICT_PERSIST - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLASH_HALF - 1);

  mode_t         mode_q, mode_d;
  logic [SW-1:0] su_q, su_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [FW-1:0] fl_q, fl_d;
  logic          phase_q, phase_d;
  logic [2:0]    ns_d, ew_d, cause_d;
  logic [1:0]    pns_d, pew_d;
  logic          fault_d;
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
  logic [7:0]    fcnt_d;
`endif

  logic [2:0] ns_dec, ew_dec;
  logic [1:0] pns_dec, pew_dec;
  logic       ns_ill, ew_ill, pns_ill, pew_ill;
  logic       ns_go, ew_go, c0, c1, c2, any_c;

  lamp_code_decode #(.PED(1'b0)) u_ns  (.code(ns_code),   .lamp(ns_dec),  .illegal(ns_ill));
  lamp_code_decode #(.PED(1'b0)) u_ew  (.code(ew_code),   .lamp(ew_dec),  .illegal(ew_ill));
  lamp_code_decode #(.PED(1'b1)) u_pns (.code(p_ns_code), .lamp(pns_dec), .illegal(pns_ill));
  lamp_code_decode #(.PED(1'b1)) u_pew (.code(p_ew_code), .lamp(pew_dec), .illegal(pew_ill));

  // Conflict terms work on the decoded lamps, so an illegal vehicle code
  // counts as red here and is caught by c2 instead.
  always_comb begin
    ns_go = ns_dec[2] | ns_dec[1];
    ew_go = ew_dec[2] | ew_dec[1];
    c0    = ns_go & ew_go;
    c1    = (pns_dec[1] & ns_go) | (pew_dec[1] & ew_go);
    c2    = ns_ill | ew_ill | pns_ill | pew_ill;
    any_c = c0 | c1 | c2;
  end

  // Next-state and next-output logic. Lamps default to the safe all-red
  // drive; only a cycle that stays in NORMAL passes the decode through, so
  // the edge that latches a fault never shows the conflicting decode.
  // The flash phase is computed before the lamp drive so the registered
  // lamp tracks the registered phase (phase 0 = red on).
  always_comb begin
    mode_d  = mode_q;
    su_d    = su_q;
    pc_d    = '0;
    fl_d    = fl_q;
    phase_d = phase_q;
    ns_d    = VL_RED;
    ew_d    = VL_RED;
    pns_d   = PL_DONT;
    pew_d   = PL_DONT;
    fault_d = fault;
    cause_d = fault_cause;
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
    fcnt_d  = fault_count;
`endif
    case (mode_q)
      STARTUP: begin
        if (su_q == SU_LAST) begin
          mode_d = NORMAL;
          su_d   = '0;
        end else begin
          su_d = su_q + SW'(1);
        end
      end
      NORMAL: begin
        if (any_c && (pc_q == PC_LAST)) begin
          mode_d  = FAULT;
          fault_d = 1'b1;
          cause_d = {c2, c1, c0};
          fl_d    = '0;
          phase_d = 1'b0;
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
          if (fault_count != 8'hFF) fcnt_d = fault_count + 8'd1;
`endif
        end else begin
          if (any_c) pc_d = pc_q + PW'(1);
          ns_d  = ns_dec;
          ew_d  = ew_dec;
          pns_d = pns_dec;
          pew_d = pew_dec;
        end
      end
      FAULT: begin
        if (fault_clr && !any_c) begin
          mode_d  = STARTUP;
          su_d    = '0;
          fault_d = 1'b0;
          cause_d = '0;
        end else begin
          if (fl_q == FL_LAST) begin
            fl_d    = '0;
            phase_d = ~phase_q;
          end else begin
            fl_d = fl_q + FW'(1);
          end
          ns_d = phase_d ? VL_OFF : VL_RED;
          ew_d = phase_d ? VL_OFF : VL_RED;
        end
      end
      default: mode_d = STARTUP;
    endcase
  end

  // State and output registers; reset overrides every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= STARTUP;
      su_q        <= '0;
      pc_q        <= '0;
      fl_q        <= '0;
      phase_q     <= 1'b0;
      ns_lamp     <= VL_RED;
      ew_lamp     <= VL_RED;
      p_ns_lamp   <= PL_DONT;
      p_ew_lamp   <= PL_DONT;
      fault       <= 1'b0;
      fault_cause <= '0;
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
      fault_count <= '0;
`endif
    end else begin
      mode_q      <= mode_d;
      su_q        <= su_d;
      pc_q        <= pc_d;
      fl_q        <= fl_d;
      phase_q     <= phase_d;
      ns_lamp     <= ns_d;
      ew_lamp     <= ew_d;
      p_ns_lamp   <= pns_d;
      p_ew_lamp   <= pew_d;
      fault       <= fault_d;
      fault_cause <= cause_d;
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
      fault_count <= fcnt_d;
`endif
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_lamp_monitor
// Directed bench for traffic_lamp_monitor with default parameters
// (STARTUP_CYCLES=8, CONFLICT_PERSIST=2, FLASH_HALF=4). Each step drives
// inputs, queues the outputs expected after the next clock edge, then pops
// and compares them 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_traffic_lamp_monitor;

  localparam logic [2:0] CR = 3'b001, CY = 3'b010, CG = 3'b011;
  localparam logic [2:0] VR = 3'b001, VY = 3'b010, VG = 3'b100, VO = 3'b000;
  localparam logic [1:0] DW = 2'b01, WK = 2'b10;
  localparam logic [1:0] MS = 2'b00, MN = 2'b01, MF = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ns_code, ew_code, p_ns_code, p_ew_code;
  logic       fault_clr;
  logic [2:0] ns_lamp, ew_lamp;
  logic [1:0] p_ns_lamp, p_ew_lamp;
  logic       fault;
  logic [2:0] fault_cause;
  logic [1:0] mode;
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
  logic [7:0] fault_count;
`endif

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [1:0] pns;
    logic [1:0] pew;
    logic       fault;
    logic [2:0] cause;
    logic [7:0] fcnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fc = 8'd0;

  always #5 clk = ~clk;

  traffic_lamp_monitor dut (
    .clk(clk), .rst(rst),
    .ns_code(ns_code), .ew_code(ew_code),
    .p_ns_code(p_ns_code), .p_ew_code(p_ew_code),
    .fault_clr(fault_clr),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .p_ns_lamp(p_ns_lamp), .p_ew_lamp(p_ew_lamp),
    .fault(fault), .fault_cause(fault_cause),
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
    .fault_count(fault_count),
`endif
    .mode(mode)
  );

  function automatic exp_t mk(string tag, logic [1:0] m, logic [2:0] ns, logic [2:0] ew,
                              logic [1:0] pns, logic [1:0] pew, logic f, logic [2:0] c,
                              logic [7:0] fcnt);
    exp_t e;
    e.tag = tag; e.mode = m; e.ns = ns; e.ew = ew; e.pns = pns; e.pew = pew;
    e.fault = f; e.cause = c; e.fcnt = fcnt;
    return e;
  endfunction

  task automatic checkField(string tag, string field, logic [7:0] got, logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s.%s got %b want %b", tag, field, got, want);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      checkField(e.tag, "mode",        {6'd0, mode},        {6'd0, e.mode});
      checkField(e.tag, "ns_lamp",     {5'd0, ns_lamp},     {5'd0, e.ns});
      checkField(e.tag, "ew_lamp",     {5'd0, ew_lamp},     {5'd0, e.ew});
      checkField(e.tag, "p_ns_lamp",   {6'd0, p_ns_lamp},   {6'd0, e.pns});
      checkField(e.tag, "p_ew_lamp",   {6'd0, p_ew_lamp},   {6'd0, e.pew});
      checkField(e.tag, "fault",       {7'd0, fault},       {7'd0, e.fault});
      checkField(e.tag, "fault_cause", {5'd0, fault_cause}, {5'd0, e.cause});
`ifdef TRAFFIC_LAMP_FAULT_CNT_EN
      checkField(e.tag, "fault_count", fault_count, e.fcnt);
`endif
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] ns, input logic [2:0] ew,
                               input logic [2:0] pns, input logic [2:0] pew,
                               input logic clr, input exp_t e);
    rst       = r;
    ns_code   = ns;
    ew_code   = ew;
    p_ns_code = pns;
    p_ew_code = pew;
    fault_clr = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; ns_code = CG; ew_code = CR; p_ns_code = CR; p_ew_code = CG; fault_clr = 1'b0;

    // Reset, then the startup hold with the first test-plan codes
    repeat (2) applyStimulus(1, CG, CR, CR, CG, 0, mk("reset", MS, VR, VR, DW, DW, 0, 3'b000, fc));
    repeat (7) applyStimulus(0, CG, CR, CR, CG, 0, mk("startup", MS, VR, VR, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CG, CR, CR, CG, 0, mk("to_normal", MN, VR, VR, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CG, CR, CR, CG, 0, mk("normal0", MN, VG, VR, DW, WK, 0, 3'b000, fc));

    // ns steps down through yellow to red
    applyStimulus(0, CY, CR, CR, CG, 0, mk("ns_yel", MN, VY, VR, DW, WK, 0, 3'b000, fc));
    applyStimulus(0, CR, CR, CR, CG, 0, mk("ns_red", MN, VR, VR, DW, WK, 0, 3'b000, fc));
    applyStimulus(0, CG, CR, CR, CR, 0, mk("ns_grn", MN, VG, VR, DW, DW, 0, 3'b000, fc));

    // Single-cycle conflicts twice in a row must not accumulate
    applyStimulus(0, CG, CY, CR, CR, 0, mk("conf1_a", MN, VG, VY, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CG, CR, CR, CR, 0, mk("calm_a", MN, VG, VR, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CG, CY, CR, CR, 0, mk("conf1_b", MN, VG, VY, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CG, CR, CR, CR, 0, mk("calm_b", MN, VG, VR, DW, DW, 0, 3'b000, fc));

    // Persistent vehicle conflict latches a fault on the second cycle
    applyStimulus(0, CG, CG, CR, CR, 0, mk("veh_conf1", MN, VG, VG, DW, DW, 0, 3'b000, fc));
    fc = 8'd1;
    applyStimulus(0, CG, CG, CR, CR, 0, mk("veh_fault", MF, VR, VR, DW, DW, 1, 3'b001, fc));

    // Clear attempts with conflicting / illegal codes are ignored
    applyStimulus(0, CG, CG, CR, CR, 1, mk("clr_conf", MF, VR, VR, DW, DW, 1, 3'b001, fc));
    applyStimulus(0, CR, 3'b101, CR, CR, 1, mk("clr_ill", MF, VR, VR, DW, DW, 1, 3'b001, fc));
    applyStimulus(0, CR, CR, CR, CR, 0, mk("flash_on", MF, VR, VR, DW, DW, 1, 3'b001, fc));
    repeat (4) applyStimulus(0, CR, CR, CR, CR, 0, mk("flash_off", MF, VO, VO, DW, DW, 1, 3'b001, fc));
    applyStimulus(0, CR, CR, CR, CR, 0, mk("flash_on2", MF, VR, VR, DW, DW, 1, 3'b001, fc));

    // Honoured clear restarts the full startup hold
    applyStimulus(0, CR, CR, CR, CR, 1, mk("fault_clr", MS, VR, VR, DW, DW, 0, 3'b000, fc));
    repeat (7) applyStimulus(0, CR, CG, CG, CR, 0, mk("restart", MS, VR, VR, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CR, CG, CG, CR, 0, mk("to_normal2", MN, VR, VR, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CR, CG, CG, CR, 0, mk("normal2", MN, VR, VG, WK, DW, 0, 3'b000, fc));

    // Pedestrian conflict: walk while ns is green
    applyStimulus(0, CG, CR, CG, CR, 0, mk("ped_conf1", MN, VG, VR, WK, DW, 0, 3'b000, fc));
    fc = 8'd2;
    applyStimulus(0, CG, CR, CG, CR, 0, mk("ped_fault", MF, VR, VR, DW, DW, 1, 3'b010, fc));
    repeat (3) applyStimulus(0, CG, CR, CG, CR, 0, mk("ped_on", MF, VR, VR, DW, DW, 1, 3'b010, fc));
    applyStimulus(0, CG, CR, CG, CR, 0, mk("ped_off", MF, VO, VO, DW, DW, 1, 3'b010, fc));

    // Reset during the off phase
    fc = 8'd0;
    applyStimulus(1, CG, CR, CG, CR, 0, mk("rst_mid", MS, VR, VR, DW, DW, 0, 3'b000, fc));
    applyStimulus(0, CG, CR, CG, CR, 0, mk("post_rst", MS, VR, VR, DW, DW, 0, 3'b000, fc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
